// File: rtl/fib_bcd_if.sv
// Handshake bundle for the binary-to-BCD converter: start request with operand,
// busy/valid status and the packed BCD result with its significant-digit count.
interface fib_bcd_if #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
);
  logic                  i_stb;
  logic [WIDTH-1:0]      i_bin;
  logic                  i_ack;
  logic                  o_busy;
  logic                  o_valid;
  logic [4*DIGITS-1:0]   o_bcd;
  logic [4:0]            o_ndigits;

  modport master (
    output i_stb, i_bin, i_ack,
    input  o_busy, o_valid, o_bcd, o_ndigits
  );

  modport slave (
    input  i_stb, i_bin, i_ack,
    output o_busy, o_valid, o_bcd, o_ndigits
  );
endinterface

// File: rtl/fib_bcd.sv
// Sequential double-dabble converter: one binary bit per cycle into a packed BCD
// accumulator, result held in DONE until acknowledged.
module fib_bcd #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
) (
  input  logic         i_clk,
  input  logic         i_reset,
  fib_bcd_if.slave     bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [4:0]       ndigits_q, ndigits_d;
  logic [BW-1:0]    adj_s;
  logic             busy_s, valid_s;

  function automatic logic [BW-1:0] add3_digits(input logic [BW-1:0] bcd);
    logic [BW-1:0] r;
    logic [3:0]    dig;
    r = '0;
    for (int d = 0; d < DIGITS; d++) begin
      dig = bcd[4*d +: 4];
      r[4*d +: 4] = (dig >= 4'd5) ? dig + 4'd3 : dig;
    end
    return r;
  endfunction

  // Highest nonzero digit position plus one; an all-zero value still has one digit.
  function automatic logic [4:0] count_digits(input logic [BW-1:0] bcd);
    logic [4:0] n;
    n = 5'd1;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd[4*d +: 4] != 4'd0) begin
        n = 5'(d + 1);
      end else begin
        n = n;
      end
    end
    return n;
  endfunction

  // State and datapath registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      ndigits_q <= 5'd1;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      ndigits_q <= ndigits_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = bus.i_stb ? SHIFT : IDLE;
      SHIFT:   state_d = (cnt_q == CW'(1)) ? DONE : SHIFT;
      DONE:    state_d = bus.i_ack ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: load on accept, adjust-then-shift while converting, hold otherwise
  always_comb begin
    adj_s = add3_digits(bcd_q);
    bin_d = bin_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.i_stb) begin
          bin_d = bus.i_bin;
          bcd_d = '0;
          cnt_d = CW'(WIDTH);
        end else begin
          bin_d = bin_q;
        end
      end
      SHIFT: begin
        {bcd_d, bin_d} = {adj_s[BW-2:0], bin_q, 1'b0};
        cnt_d          = cnt_q - CW'(1);
      end
      DONE:    bcd_d = bcd_q;
      default: bcd_d = bcd_q;
    endcase
    ndigits_d = count_digits(bcd_d);
  end

  // Status outputs decoded from the state register
  always_comb begin
    busy_s  = (state_q != IDLE);
    valid_s = (state_q == DONE);
  end

  assign bus.o_busy    = busy_s;
  assign bus.o_valid   = valid_s;
  assign bus.o_bcd     = bcd_q;
  assign bus.o_ndigits = ndigits_q;
endmodule

// File: tb/tb_fib_bcd.sv
// Scoreboard bench for fib_bcd: driver pushes decimal-arithmetic expectations,
// a negedge monitor pops and compares on every rising o_valid.
module tb_fib_bcd;
  localparam int WIDTH  = 32;
  localparam int DIGITS = 10;
  localparam int BW     = 4 * DIGITS;

  logic clk = 1'b0;
  logic rst;

  fib_bcd_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

  fib_bcd #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [BW-1:0] bcd;
    logic [4:0]    nd;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_valid_cyc = -1;
  int   prev_valid_cyc = -1;

  function automatic logic [BW-1:0] ref_bcd(input logic [WIDTH-1:0] v);
    longint unsigned x;
    logic [BW-1:0]   r;
    x = longint'(v);
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [4:0] ref_nd(input logic [WIDTH-1:0] v);
    longint unsigned x;
    int n;
    x = longint'(v);
    n = 1;
    while (x >= 10) begin
      x = x / 10;
      n++;
    end
    return 5'(n);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Monitor: compare each new result against the scoreboard, then check it holds.
  initial begin
    logic          valid_prev;
    logic [BW-1:0] held;
    exp_t          e;
    valid_prev = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (bus.o_valid === 1'b1 && !valid_prev) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_result: got %0h expected none", bus.o_bcd);
        end else begin
          e = exp_q.pop_front();
          check("bcd", 64'(bus.o_bcd), 64'(e.bcd));
          check("ndigits", 64'(bus.o_ndigits), 64'(e.nd));
        end
        held = bus.o_bcd;
        prev_valid_cyc = last_valid_cyc;
        last_valid_cyc = cyc;
      end else if (bus.o_valid === 1'b1) begin
        check("bcd_stable", 64'(bus.o_bcd), 64'(held));
      end
      valid_prev = (bus.o_valid === 1'b1);
    end
  end

  // Issue one conversion, optionally poking i_stb in SHIFT and alongside the ack.
  task automatic run(input logic [WIDTH-1:0] v, input int ack_dly,
                     input bit pulse_shift, input bit pulse_done);
    int t;
    int lat;
    t = 0;
    while (bus.o_busy !== 1'b0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("idle_before_start", 64'(bus.o_busy), 64'(0));
    bus.i_stb = 1'b1;
    bus.i_bin = v;
    exp_q.push_back('{bcd: ref_bcd(v), nd: ref_nd(v)});
    @(negedge clk);
    bus.i_stb = 1'b0;
    check("busy_after_accept", 64'(bus.o_busy), 64'(1));
    lat = 1;
    while (bus.o_valid !== 1'b1 && lat < 200) begin
      if (pulse_shift && lat == 5) begin
        bus.i_stb = 1'b1;
        bus.i_bin = $urandom;
      end else begin
        bus.i_stb = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus.i_stb = 1'b0;
    check("latency", 64'(lat), 64'(WIDTH + 1));
    repeat (ack_dly) @(negedge clk);
    check("valid_before_ack", 64'(bus.o_valid), 64'(1));
    bus.i_ack = 1'b1;
    if (pulse_done) begin
      bus.i_stb = 1'b1;
      bus.i_bin = $urandom;
    end
    @(negedge clk);
    bus.i_ack = 1'b0;
    bus.i_stb = 1'b0;
    check("busy_after_ack", 64'(bus.o_busy), 64'(0));
    check("valid_after_ack", 64'(bus.o_valid), 64'(0));
    check("bcd_kept_in_idle", 64'(bus.o_bcd), 64'(ref_bcd(v)));
  endtask

  // Abort a conversion with reset on its tenth shift cycle.
  task automatic reset_in_shift(input logic [WIDTH-1:0] v);
    exp_t dropped;
    bus.i_stb = 1'b1;
    bus.i_bin = v;
    exp_q.push_back('{bcd: ref_bcd(v), nd: ref_nd(v)});
    @(negedge clk);
    bus.i_stb = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    bus.i_stb = 1'b1;
    bus.i_ack = 1'b1;
    bus.i_bin = $urandom;
    @(negedge clk);
    rst = 1'b0;
    bus.i_stb = 1'b0;
    bus.i_ack = 1'b0;
    dropped = exp_q.pop_back();
    check("rst_busy", 64'(bus.o_busy), 64'(0));
    check("rst_valid", 64'(bus.o_valid), 64'(0));
    check("rst_bcd", 64'(bus.o_bcd), 64'(0));
    check("rst_ndigits", 64'(bus.o_ndigits), 64'(1));
    @(negedge clk);
    check("rst_stb_ignored", 64'(bus.o_busy), 64'(0));
  endtask

  initial begin
    rst = 1'b1;
    bus.i_stb = 1'b0;
    bus.i_ack = 1'b0;
    bus.i_bin = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(bus.o_busy), 64'(0));
    check("reset_valid", 64'(bus.o_valid), 64'(0));
    check("reset_bcd", 64'(bus.o_bcd), 64'(0));
    check("reset_ndigits", 64'(bus.o_ndigits), 64'(1));
    rst = 1'b0;
    @(negedge clk);

    run(32'd0, 0, 1'b0, 1'b0);
    run(32'hFFFF_FFFF, 1, 1'b0, 1'b0);
    run(32'd2178309, 5, 1'b0, 1'b0);
    run(32'd832040, 2, 1'b1, 1'b1);
    reset_in_shift($urandom);
    run(32'd55, 0, 1'b0, 1'b0);

    run(32'd1, 0, 1'b0, 1'b0);
    run(32'd1346269, 0, 1'b0, 1'b0);
    check("b2b_spacing", 64'(last_valid_cyc - prev_valid_cyc), 64'(WIDTH + 2));

    for (int i = 0; i < 12; i++) begin
      logic [WIDTH-1:0] v;
      case (i % 3)
        0:       v = $urandom;
        1:       v = WIDTH'($urandom_range(0, 99999));
        default: v = WIDTH'($urandom_range(0, 9));
      endcase
      run(v, $urandom_range(0, 4), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fib_bcd.md
FIB_BCD -- requirements
Module: fib_bcd

Interface
REQ-001 SHALL have parameter WIDTH, default 32, binary input width in bits.
REQ-002 SHALL have parameter DIGITS, default 10, number of BCD output digits; DIGITS SHALL satisfy 10^DIGITS > 2^WIDTH-1.
REQ-003 SHALL have port i_clk  input  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port i_reset  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port i_stb  input  1  start request; qualifies i_bin.
REQ-006 SHALL have port i_bin  input  WIDTH  unsigned binary value to convert (the fib result word).
REQ-007 SHALL have port o_busy  output  1  high whenever a new i_stb will not be accepted.
REQ-008 SHALL have port o_valid  output  1  conversion result present on o_bcd.
REQ-009 SHALL have port i_ack  input  1  consumer has taken the result.
REQ-010 SHALL have port o_bcd  output  4*DIGITS  packed BCD; digit 0 (units) in bits [3:0].
REQ-011 SHALL have port o_ndigits  output  5  count of significant decimal digits in o_bcd, range 1..DIGITS.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-013 o_busy SHALL equal (state != IDLE); o_valid SHALL equal (state == DONE).
REQ-014 In IDLE with i_stb=1: latch i_bin into a shift register, clear the BCD accumulator to 0, load the bit counter with WIDTH, go to SHIFT.
REQ-015 In IDLE with i_stb=0: hold all registers.
REQ-016 In SHIFT, each cycle: add 3 to every BCD digit >= 5; then shift {BCD, binary} left one bit, with the binary MSB entering BCD bit 0; decrement the counter.
REQ-017 SHIFT SHALL last exactly WIDTH cycles, then go to DONE; o_valid SHALL rise on edge WIDTH+1 counted from the edge that sampled i_stb.
REQ-018 All digit arithmetic SHALL be 4-bit modulo; no digit SHALL exceed 9 in DONE.
REQ-019 In DONE: o_bcd and o_ndigits SHALL stay stable until i_ack=1; with i_ack=1, go to IDLE on that edge.
REQ-020 i_stb SHALL be ignored in SHIFT and DONE, including a cycle where i_ack=1 in DONE (o_busy is still high); a new request needs i_stb while IDLE.
REQ-021 o_ndigits SHALL be 1 + index of the most significant nonzero digit of o_bcd; an all-zero o_bcd gives 1.
REQ-022 o_bcd SHALL keep the last result after IDLE is re-entered, until the next i_stb is accepted.
REQ-023 Back-to-back throughput SHALL be one conversion per WIDTH+2 cycles: accept, WIDTH shifts, DONE with immediate ack.

Reset
REQ-024 i_reset=1 SHALL force state IDLE, o_busy=0, o_valid=0, o_bcd=0, o_ndigits=1, counter=0, shift register=0.
REQ-025 Reset SHALL take precedence over i_stb and i_ack in the same cycle.
REQ-026 Reset SHALL abort a conversion in SHIFT or DONE with no partial result kept; the first i_stb after reset SHALL be accepted normally.

Verification
REQ-027 i_bin=0, i_stb pulse -> o_valid high 33 edges later, o_bcd=0x0000000000, o_ndigits=1.
REQ-028 i_bin=0xFFFFFFFF -> o_bcd=0x4294967295, o_ndigits=10; i_bin=2178309 -> o_bcd=0x0002178309, o_ndigits=7.
REQ-029 i_stb pulses during SHIFT and during DONE (the DONE pulse together with i_ack) -> both ignored, first result unchanged, state IDLE after ack.
REQ-030 i_ack held low for 5 cycles in DONE -> o_valid and o_bcd stable through all 5; ack -> o_busy low next cycle.
REQ-031 i_reset asserted on SHIFT cycle 10 -> all outputs at reset values next edge; then i_bin=55 -> o_bcd=0x0000000055, o_ndigits=2.
REQ-032 Back-to-back: i_stb re-asserted the cycle after ack, i_bin=1 then 1346269 -> results 0x0000000001 and 0x0001346269, spaced 34 cycles.
